// File: rtl/riscv_alu.sv
// riscv_alu: single-cycle-latency registered RV32-style ALU with valid handshake.
// Optional shifter (SLL/SRL/SRA) built only when RISCV_ALU_SHIFT_EN is defined.
`default_nettype none

module riscv_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [3:0]       ALUctl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] ALUout,
  output logic             zero,
  output logic             out_valid
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

`ifdef RISCV_ALU_SHIFT_EN
  localparam int         SHW    = $clog2(WIDTH);
  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_SRL = 4'b1001;
  localparam logic [3:0] OP_SRA = 4'b1010;

  logic [SHW-1:0] shamt;
  assign shamt = B[SHW-1:0];
`endif

  logic [WIDTH-1:0] result_d;
  logic             zero_d;
  logic [WIDTH-1:0] alu_q;
  logic             zero_q;
  logic             valid_q;
  logic             slt_lt;

  assign slt_lt = ($signed(A) < $signed(B));

  always_comb begin
    result_d = '0;
    unique case (ALUctl)
      OP_AND:  result_d = A & B;
      OP_OR:   result_d = A | B;
      OP_ADD:  result_d = A + B;
      OP_SUB:  result_d = A - B;
      OP_SLT:  result_d = {{(WIDTH-1){1'b0}}, slt_lt};
      OP_NOR:  result_d = ~(A | B);
`ifdef RISCV_ALU_SHIFT_EN
      OP_SLL:  result_d = A << shamt;
      OP_SRL:  result_d = A >> shamt;
      OP_SRA:  result_d = $unsigned($signed(A) >>> shamt);
`endif
      default: result_d = '0;
    endcase
  end

  // Flag derives from the same result being captured, so it can never lag ALUout.
  assign zero_d = (result_d == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_q   <= '0;
      zero_q  <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      if (in_valid) begin
        alu_q  <= result_d;
        zero_q <= zero_d;
      end
      valid_q <= in_valid;
    end
  end

  assign ALUout    = alu_q;
  assign zero      = zero_q;
  assign out_valid = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_riscv_alu.sv
// tb_riscv_alu: directed literal checks plus randomized traffic against a behavioural model.
`default_nettype none

module tb_riscv_alu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  ALUctl = 4'h0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [31:0] ALUout;
  logic        zero;
  logic        out_valid;

  int tests = 0;
  int fails = 0;

  logic [31:0] m_out   = '0;
  logic        m_zero  = 1'b1;
  logic        m_valid = 1'b0;

  riscv_alu #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .ALUctl    (ALUctl),
    .A         (A),
    .B         (B),
    .ALUout    (ALUout),
    .zero      (zero),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  function automatic longint to_signed(input logic [31:0] v);
    longint x;
    x = longint'(v);
    if (v >= 32'h8000_0000) x = x - 64'sd4294967296;
    return x;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [3:0] ctl, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa;
    longint sb;
    int     sh;
    sa = to_signed(a);
    sb = to_signed(b);
    sh = int'(b % 32);
    case (ctl)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return 32'((longint'(a) + longint'(b)) % 64'sd4294967296);
      4'b0110: return 32'((longint'(a) - longint'(b) + 64'sd4294967296) % 64'sd4294967296);
      4'b0111: return (sa < sb) ? 32'd1 : 32'd0;
      4'b1100: return 32'hFFFF_FFFF ^ (a | b);
`ifdef RISCV_ALU_SHIFT_EN
      4'b1000: return 32'(longint'(a) * (64'sd1 << sh));
      4'b1001: return 32'(longint'(a) / (64'sd1 << sh));
      4'b1010: begin
        // Floor division of the signed value gives arithmetic-shift semantics.
        longint q;
        q = sa / (64'sd1 << sh);
        if ((sa < 0) && (q * (64'sd1 << sh) != sa)) q = q - 1;
        return 32'(q);
      end
`endif
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_out   = '0;
      m_zero  = 1'b1;
      m_valid = 1'b0;
    end else begin
      if (in_valid) begin
        m_out  = ref_alu(ALUctl, A, B);
        m_zero = (m_out == 32'h0);
      end
      m_valid = in_valid;
    end
  end

  task automatic check(input string name, input logic [31:0] exp_out, input logic exp_zero,
                       input logic exp_valid);
    tests++;
    if (ALUout !== exp_out || zero !== exp_zero || out_valid !== exp_valid) begin
      fails++;
      $display("FAIL %s: got ALUout=%h zero=%b out_valid=%b, expected ALUout=%h zero=%b out_valid=%b",
               name, ALUout, zero, out_valid, exp_out, exp_zero, exp_valid);
    end
  endtask

  always @(negedge clk) begin
    check("model", m_out, m_zero, m_valid);
  end

  task automatic drive(input logic v, input logic [3:0] ctl, input logic [31:0] a,
                       input logic [31:0] b);
    @(posedge clk);
    #1;
    in_valid = v;
    ALUctl   = ctl;
    A        = a;
    B        = b;
    #1;
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 32'h0, 1'b1, 1'b0);
    rst_n = 1'b1;

    drive(1'b1, 4'b0000, 32'h0000_000F, 32'h0000_000A);
    drive(1'b1, 4'b0001, 32'h0000_0000, 32'h0000_000A);
    check("and", 32'h0000_000A, 1'b0, 1'b1);
    drive(1'b1, 4'b0010, 32'h0000_0009, 32'h0000_0001);
    check("or", 32'h0000_000A, 1'b0, 1'b1);
    drive(1'b1, 4'b0110, 32'h0000_000F, 32'h0000_000F);
    check("add", 32'h0000_000A, 1'b0, 1'b1);
    drive(1'b1, 4'b0111, 32'h0000_0008, 32'h0000_0009);
    check("sub_zero", 32'h0, 1'b1, 1'b1);
    drive(1'b1, 4'b0111, 32'h0000_000A, 32'h0000_0009);
    check("slt_true", 32'h1, 1'b0, 1'b1);
    drive(1'b1, 4'b0111, 32'h8000_0000, 32'h7FFF_FFFF);
    check("slt_false", 32'h0, 1'b1, 1'b1);
    drive(1'b1, 4'b0111, 32'h1234_5678, 32'h1234_5678);
    check("slt_min_vs_max", 32'h1, 1'b0, 1'b1);
    drive(1'b1, 4'b1100, 32'h0000_0000, 32'h0000_000A);
    check("slt_equal", 32'h0, 1'b1, 1'b1);
    drive(1'b1, 4'b0101, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("nor", 32'hFFFF_FFF5, 1'b0, 1'b1);
    drive(1'b1, 4'b0010, 32'hFFFF_FFFF, 32'h0000_0001);
    check("undef_op", 32'h0, 1'b1, 1'b1);
    drive(1'b1, 4'b0110, 32'h0000_0000, 32'h0000_0001);
    check("add_wrap", 32'h0, 1'b1, 1'b1);
    drive(1'b1, 4'b1010, 32'h8000_0000, 32'h0000_0024);
    check("sub_wrap", 32'hFFFF_FFFF, 1'b0, 1'b1);
    drive(1'b1, 4'b1000, 32'h0000_0001, 32'h0000_001F);
`ifdef RISCV_ALU_SHIFT_EN
    check("sra", 32'hF800_0000, 1'b0, 1'b1);
`else
    check("sra_disabled", 32'h0, 1'b1, 1'b1);
`endif
    drive(1'b1, 4'b0010, 32'h0000_0009, 32'h0000_0001);
`ifdef RISCV_ALU_SHIFT_EN
    check("sll", 32'h8000_0000, 1'b0, 1'b1);
`else
    check("sll_disabled", 32'h0, 1'b1, 1'b1);
`endif
    drive(1'b0, 4'b0001, 32'hFFFF_FFFF, 32'h0);
    check("add_before_hold", 32'h0000_000A, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 4'($urandom_range(0, 15)), $urandom, $urandom);
      check("hold", 32'h0000_000A, 1'b0, 1'b0);
    end

    drive(1'b1, 4'b0010, 32'h0000_0003, 32'h0000_0004);
    drive(1'b0, 4'b0000, 32'h0, 32'h0);
    check("pre_reset", 32'h0000_0007, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    check("async_reset", 32'h0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b1;
    ALUctl   = 4'b0010;
    A        = 32'h2;
    B        = 32'h2;
    #1;
    check("after_release", 32'h0, 1'b1, 1'b0);
    drive(1'b0, 4'b0000, 32'h0, 32'h0);
    check("first_after_reset", 32'h0000_0004, 1'b0, 1'b1);

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      case ($urandom_range(0, 3))
        0:       ra = 32'h8000_0000;
        1:       ra = 32'hFFFF_FFFF;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 3))
        0:       rb = 32'h7FFF_FFFF;
        1:       rb = ra;
        default: rb = $urandom;
      endcase
      in_valid = ($urandom_range(0, 3) != 0);
      ALUctl   = 4'($urandom_range(0, 15));
      A        = ra;
      B        = rb;
      if ($urandom_range(0, 99) == 0) begin
        #1;
        rst_n = 1'b0;
      end
    end

    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
